// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage: decodes a 4-bit ALU control code, computes result and
//   flags combinationally from two operands, and registers each operation
//   (with its tag) into a 2-entry in-order output buffer with a
//   valid/ready handshake on both sides.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake (in_ready is registered-only)
//   alu_control, src_a, src_b  operation code and operands
//   in_tag                     tag carried unchanged with the operation
//   out_valid / out_ready      downstream handshake for the head entry
//   result, zero, overflow,
//   illegal, out_tag           head entry contents (driven 0 when empty)
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Entry layout: {result, zero, overflow, illegal, tag}
  localparam int ENT_W = WIDTH + 3 + TAG_W;

  // -------------------------------------------------------------------------
  // Combinational ALU
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_illegal;

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  // Operands share a sign but the sum's sign differs.
  assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  // Operands differ in sign and the difference's sign differs from A.
  assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
  // Signed less-than: the difference sign, corrected when the subtraction overflowed.
  assign lt = diff[WIDTH-1] ^ sub_ovf;

  always_comb begin
    alu_result  = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    unique case (alu_control)
      4'b0010: begin
        alu_result = sum;
        alu_ovf    = add_ovf;
      end
      4'b0110: begin
        alu_result = diff;
        alu_ovf    = sub_ovf;
      end
      4'b0000: alu_result = src_a & src_b;
      4'b0001: alu_result = src_a | src_b;
      4'b1101: alu_result = src_a ^ src_b;
      4'b1100: alu_result = ~(src_a | src_b);
      4'b0111: alu_result = {{(WIDTH-1){1'b0}}, lt};
      default: alu_illegal = 1'b1;
    endcase
  end

  logic [ENT_W-1:0] new_entry;
  assign new_entry = {alu_result, (alu_result == '0), alu_ovf, alu_illegal, in_tag};

  // -------------------------------------------------------------------------
  // 2-entry FIFO control
  // -------------------------------------------------------------------------
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       accept;
  logic       deliver;

  // Both depend only on registered state, so there is no path from out_ready
  // to in_ready; a slot freed while full is reusable only in the next cycle.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    unique case ({accept, deliver})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (accept) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (deliver) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage: one register per slot, written when the write pointer
  // selects it.
  // -------------------------------------------------------------------------
  logic [1:0][ENT_W-1:0] entries;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [ENT_W-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (accept && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= new_entry;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Head outputs: forced to zero when the buffer is empty so that reset and
  // idle present a clean all-zero bus.
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0] head;
  assign head = out_valid ? entries[rd_ptr_reg] : '0;

  assign result   = head[ENT_W-1 -: WIDTH];
  assign zero     = head[TAG_W+2];
  assign overflow = head[TAG_W+1];
  assign illegal  = head[TAG_W];
  assign out_tag  = head[TAG_W-1:0];

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage (WIDTH=32, TAG_W=5). A queue-based
//   reference model tracks buffered operations; every cycle the DUT outputs
//   are compared against the model's head entry on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_control;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          illegal;
  logic [TW-1:0] out_tag;

  alu_exec_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          z;
    logic          ov;
    logic          il;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t q[$];
  int     checks    = 0;
  int     errors    = 0;
  int     delivered = 0;
  bit     post_rst  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, overflow judged by range.
  function automatic entry_t ref_op(input logic [3:0] c, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [TW-1:0] t);
    entry_t e;
    longint sa;
    longint sb;
    longint s;
    longint maxs;
    longint mins;
    maxs = 64'sd2147483647;
    mins = -64'sd2147483648;
    sa = $signed(a);
    sb = $signed(b);
    e.ov  = 1'b0;
    e.il  = 1'b0;
    e.tag = t;
    case (c)
      4'b0010: begin s = sa + sb; e.res = s[W-1:0]; e.ov = (s > maxs) || (s < mins); end
      4'b0110: begin s = sa - sb; e.res = s[W-1:0]; e.ov = (s > maxs) || (s < mins); end
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1101: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin e.res = '0; e.il = 1'b1; end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic check_outputs();
    check_val("out_valid", out_valid, q.size() != 0);
    check_val("in_ready", in_ready, q.size() != 2);
    if (q.size() != 0) begin
      check_val("result", result, q[0].res);
      check_val("zero", zero, q[0].z);
      check_val("overflow", overflow, q[0].ov);
      check_val("illegal", illegal, q[0].il);
      check_val("out_tag", out_tag, q[0].tag);
    end else if (post_rst) begin
      check_val("rst_result", result, 0);
      check_val("rst_flags", {zero, overflow, illegal}, 0);
      check_val("rst_tag", out_tag, 0);
    end
  endtask

  // One clock: check current state, drive inputs, advance the model at the
  // rising edge, return on the following falling edge.
  task automatic cycle(input logic iv, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t,
                       input logic ord, input logic rst);
    bit acc;
    bit dlv;
    check_outputs();
    in_valid    = iv;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    in_tag      = t;
    out_ready   = ord;
    reset       = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      post_rst = 1'b1;
      $display("reset");
    end else begin
      post_rst = 1'b0;
      dlv = (q.size() != 0) && ord;
      acc = iv && (q.size() < 2);
      if (dlv) begin
        $display("deliver tag=%0d result=%h z=%0b ov=%0b il=%0b",
                 q[0].tag, q[0].res, q[0].z, q[0].ov, q[0].il);
        void'(q.pop_front());
        delivered++;
      end
      if (acc) begin
        q.push_back(ref_op(c, a, b, t));
      end
    end
    @(negedge clk);
  endtask

  logic [3:0]   codes [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101, 4'b1100, 4'b0111, 4'b1111};
  logic [W-1:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  function automatic logic [W-1:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  int d0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; src_a = '0; src_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();
    post_rst = 1'b1;

    // add overflow into the sign bit
    cycle(1, 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd3, 0, 0);
    check_val("t1_valid", out_valid, 1);
    check_val("t1_result", result, 32'h80000000);
    check_val("t1_ovf_zero", {overflow, zero}, 2'b10);
    check_val("t1_tag", out_tag, 3);
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);

    // sub to zero, slt both directions
    cycle(1, 4'b0110, 32'd5, 32'd5, 5'd1, 1, 0);
    check_val("t2_sub", {result, zero, overflow}, {32'h0, 2'b10});
    cycle(1, 4'b0111, 32'hFFFFFFFE, 32'd1, 5'd2, 1, 0);
    check_val("t2_slt_neg", result, 1);
    cycle(1, 4'b0111, 32'd1, 32'hFFFFFFFE, 5'd3, 1, 0);
    check_val("t2_slt_pos", result, 0);
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);

    // fill under backpressure, then drain in order
    cycle(1, 4'b0000, 32'hF0F0, 32'hFF00, 5'd4, 0, 0);
    cycle(1, 4'b1100, 32'h0, 32'h0, 5'd5, 0, 0);
    check_val("t3_full", in_ready, 0);
    check_val("t3_head", result, 32'hF000);
    cycle(1, 4'b0001, 32'h1, 32'h2, 5'd6, 1, 0);
    check_val("t3_second", result, 32'hFFFFFFFF);
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);

    // streaming: one result per cycle
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 4'b0010, 32'(i), 32'(i * 3), 5'(i + 8), 1, 0);
    end
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);
    check_val("t4_delivered", 64'(delivered - d0), 8);

    // unsupported code
    cycle(1, 4'b1111, 32'd7, 32'd7, 5'd9, 0, 0);
    check_val("t5_illegal", {result, zero, overflow, illegal}, {32'h0, 3'b101});
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);

    // reset while full with an offered operation
    cycle(1, 4'b0010, 32'd1, 32'd1, 5'd1, 0, 0);
    cycle(1, 4'b0010, 32'd2, 32'd2, 5'd2, 0, 0);
    cycle(1, 4'b0010, 32'd3, 32'd3, 5'd3, 0, 1);
    check_val("t6_valid", out_valid, 0);
    check_val("t6_ready", in_ready, 1);
    cycle(0, 4'b0000, 0, 0, 0, 1, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
      cycle($urandom_range(0, 3) != 0, c, pick_operand(), pick_operand(), 5'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
